// File: rtl/stopwatch_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_pkg
//  Description : Shared types and constants for the stopwatch core: state
//                encoding, seconds limit and the minute-width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package stopwatch_pkg;

    // Operating modes of the core
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_ADJ     = 2'd2,
        ST_EXPIRED = 2'd3
    } sw_state_e;

    // Highest seconds value shown on the display
    localparam logic [5:0] SEC_MAX = 6'd59;

    // Bits needed to hold 0..max_min (never narrower than one bit)
    function automatic int min_width(input int max_min);
        return (max_min < 1) ? 1 : $clog2(max_min + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/stopwatch_core_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tick_gen
//  Description : Prescaler for the stopwatch core. Produces the one-second
//                tick, the adjust-step strobe and the adjust blink phase as
//                clock enables within the single clk domain.
//  Revision    : 1.0 - initial release
// ============================================================================
module tick_gen #(
    parameter int TICK_DIV     = 100000000,
    parameter int ADJ_RATE_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,        // state change: restart the period from zero
    input  logic en,         // count enable (RUN and ADJ)
    input  logic blink_en,   // blink phase active (ADJ only)
    output logic sec_tick,
    output logic adj_step,
    output logic blink
);

    localparam int              CNT_W    = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(TICK_DIV / 2 - 1);
    localparam logic [31:0]      STEP_LEN = 32'(TICK_DIV / ADJ_RATE_DIV);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             blink_q, blink_d;
    logic [31:0]      cnt_ext;

    assign cnt_ext  = {{(32 - CNT_W){1'b0}}, cnt_q};
    assign sec_tick = en && (cnt_q == CNT_LAST);
    assign adj_step = en && ((cnt_ext % STEP_LEN) == (STEP_LEN - 32'd1));
    assign blink    = blink_q;

    // Next prescaler count and blink phase; a clear wins over counting
    always_comb begin
        cnt_d   = cnt_q;
        blink_d = blink_q;
        if (clr) begin
            cnt_d   = '0;
            blink_d = 1'b0;
        end else if (en) begin
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
            if (!blink_en) begin
                blink_d = 1'b0;
            end else if ((cnt_q == CNT_HALF) || (cnt_q == CNT_LAST)) begin
                blink_d = ~blink_q;
            end
        end else begin
            blink_d = 1'b0;
        end
    end

    // Prescaler and blink registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            blink_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stopwatch_core.sv
`default_nettype none
// ============================================================================
//  Module      : stopwatch_core
//  Description : Stopwatch / countdown timekeeping core. Holds the mode FSM
//                and the minute/second registers; timing comes from tick_gen.
//                Optional lap capture is built when the macro LAP_EN is
//                defined (adds lap_p, lap_min, lap_sec, lap_valid).
//  Revision    : 1.0 - initial release
// ============================================================================
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter  int TICK_DIV     = 100000000,
    parameter  int MAX_MIN      = 59,
    parameter  int ADJ_RATE_DIV = 2,
    localparam int MIN_W        = min_width(MAX_MIN)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sel,
    input  logic             adj,
    input  logic             pause_p,
    input  logic             dir,
    output logic [MIN_W-1:0] minutes,
    output logic [5:0]       seconds,
    output logic             running,
    output logic             expired,
    output logic             blink
`ifdef LAP_EN
    ,
    input  logic             lap_p,
    output logic [MIN_W-1:0] lap_min,
    output logic [5:0]       lap_sec,
    output logic             lap_valid
`endif
);

    localparam logic [MIN_W-1:0] MIN_TOP = MIN_W'(MAX_MIN);

    sw_state_e        state_q, state_d;
    logic [MIN_W-1:0] min_q, min_d;
    logic [5:0]       sec_q, sec_d;
    logic             sec_tick;
    logic             adj_step;
    logic             tick_clr;
    logic             tick_en;
    logic             blink_en;

    // Any state change restarts the prescaler so the first tick is a full period away
    assign tick_clr = (state_d != state_q);
    assign tick_en  = (state_q == ST_RUN) || (state_q == ST_ADJ);
    assign blink_en = (state_q == ST_ADJ);

    tick_gen #(
        .TICK_DIV     (TICK_DIV),
        .ADJ_RATE_DIV (ADJ_RATE_DIV)
    ) u_tick_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (tick_clr),
        .en       (tick_en),
        .blink_en (blink_en),
        .sec_tick (sec_tick),
        .adj_step (adj_step),
        .blink    (blink)
    );

    // Mode transitions and time updates; adj overrides everything, pause wins over a tick
    always_comb begin
        state_d = state_q;
        min_d   = min_q;
        sec_d   = sec_q;
        if (adj) begin
            state_d = ST_ADJ;
            if ((state_q == ST_ADJ) && adj_step) begin
                if (sel) begin
                    sec_d = (sec_q == SEC_MAX) ? '0 : sec_q + 6'd1;
                end else begin
                    min_d = (min_q == MIN_TOP) ? '0 : min_q + 1'b1;
                end
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (pause_p) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (pause_p) begin
                        state_d = ST_IDLE;
                    end else if (sec_tick) begin
                        if (!dir) begin
                            if (sec_q == SEC_MAX) begin
                                sec_d = '0;
                                min_d = (min_q == MIN_TOP) ? '0 : min_q + 1'b1;
                            end else begin
                                sec_d = sec_q + 6'd1;
                            end
                        end else begin
                            if ((sec_q == 6'd0) && (min_q == '0)) begin
                                // Started at 00:00 counting down: expire without underflow
                                state_d = ST_EXPIRED;
                            end else if (sec_q == 6'd0) begin
                                sec_d = SEC_MAX;
                                min_d = min_q - 1'b1;
                            end else begin
                                sec_d = sec_q - 6'd1;
                                if ((sec_q == 6'd1) && (min_q == '0)) state_d = ST_EXPIRED;
                            end
                        end
                    end
                end
                ST_ADJ: begin
                    state_d = ST_IDLE;
                end
                ST_EXPIRED: begin
                    if (pause_p) state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and time registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            min_q   <= '0;
            sec_q   <= '0;
        end else begin
            state_q <= state_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
        end
    end

    assign minutes = min_q;
    assign seconds = sec_q;
    assign running = (state_q == ST_RUN);
    assign expired = (state_q == ST_EXPIRED);

`ifdef LAP_EN
    logic [MIN_W-1:0] lap_min_q, lap_min_d;
    logic [5:0]       lap_sec_q, lap_sec_d;
    logic             lap_valid_q, lap_valid_d;

    // Lap capture in RUN, lap clear in IDLE, ignored elsewhere
    always_comb begin
        lap_min_d   = lap_min_q;
        lap_sec_d   = lap_sec_q;
        lap_valid_d = lap_valid_q;
        if (lap_p) begin
            if (state_q == ST_RUN) begin
                lap_min_d   = min_q;
                lap_sec_d   = sec_q;
                lap_valid_d = 1'b1;
            end else if (state_q == ST_IDLE) begin
                lap_valid_d = 1'b0;
            end
        end
    end

    // Lap registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lap_min_q   <= '0;
            lap_sec_q   <= '0;
            lap_valid_q <= 1'b0;
        end else begin
            lap_min_q   <= lap_min_d;
            lap_sec_q   <= lap_sec_d;
            lap_valid_q <= lap_valid_d;
        end
    end

    assign lap_min   = lap_min_q;
    assign lap_sec   = lap_sec_q;
    assign lap_valid = lap_valid_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_core.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stopwatch_core
//  Description : Self-checking bench for stopwatch_core with TICK_DIV=4,
//                MAX_MIN=2. Directed scenarios plus randomized stimulus
//                against a time-in-seconds reference model. Lap checks are
//                included when LAP_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stopwatch_core;

    localparam int TICK_DIV     = 4;
    localparam int MAX_MIN      = 2;
    localparam int ADJ_RATE_DIV = 2;
    localparam int MIN_W        = 2;
    localparam int S_IDLE = 0, S_RUN = 1, S_ADJ = 2, S_EXP = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             sel = 1'b0;
    logic             adj = 1'b0;
    logic             pause_p = 1'b0;
    logic             dir = 1'b0;
    logic [MIN_W-1:0] minutes;
    logic [5:0]       seconds;
    logic             running;
    logic             expired;
    logic             blink;
`ifdef LAP_EN
    logic             lap_p = 1'b0;
    logic [MIN_W-1:0] lap_min;
    logic [5:0]       lap_sec;
    logic             lap_valid;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: mode, elapsed cycles in the mode, time as total seconds
    int m_state, m_ph, m_t, m_lap_t;
    bit m_blink, m_lap_v;

    stopwatch_core #(
        .TICK_DIV     (TICK_DIV),
        .MAX_MIN      (MAX_MIN),
        .ADJ_RATE_DIV (ADJ_RATE_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sel       (sel),
        .adj       (adj),
        .pause_p   (pause_p),
        .dir       (dir),
        .minutes   (minutes),
        .seconds   (seconds),
        .running   (running),
        .expired   (expired),
        .blink     (blink)
`ifdef LAP_EN
        ,
        .lap_p     (lap_p),
        .lap_min   (lap_min),
        .lap_sec   (lap_sec),
        .lap_valid (lap_valid)
`endif
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = S_IDLE; m_ph = 0; m_t = 0; m_blink = 0;
        m_lap_t = 0; m_lap_v = 0;
    endtask

    // One clock edge of the specified behaviour
    task automatic model_update();
        int  ns, mm, ss;
        bit  tick, step;
        if (!rst_n) begin
            model_reset();
            return;
        end
        tick = (m_ph == TICK_DIV - 1);
        step = ((m_ph + 1) % (TICK_DIV / ADJ_RATE_DIV)) == 0;
        ns   = m_state;
`ifdef LAP_EN
        if (lap_p) begin
            if (m_state == S_RUN) begin
                m_lap_t = m_t; m_lap_v = 1;
            end else if (m_state == S_IDLE) begin
                m_lap_v = 0;
            end
        end
`endif
        if (adj) begin
            ns = S_ADJ;
            if (m_state == S_ADJ && step) begin
                mm = m_t / 60; ss = m_t % 60;
                if (sel) ss = (ss + 1) % 60;
                else     mm = (mm + 1) % (MAX_MIN + 1);
                m_t = mm * 60 + ss;
            end
        end else begin
            case (m_state)
                S_IDLE: if (pause_p) ns = S_RUN;
                S_RUN: begin
                    if (pause_p) ns = S_IDLE;
                    else if (tick) begin
                        if (!dir) m_t = (m_t + 1) % ((MAX_MIN + 1) * 60);
                        else if (m_t == 0) ns = S_EXP;
                        else begin
                            m_t = m_t - 1;
                            if (m_t == 0) ns = S_EXP;
                        end
                    end
                end
                S_ADJ: ns = S_IDLE;
                default: if (pause_p) ns = S_IDLE;
            endcase
        end
        if (ns != m_state) begin
            m_ph = 0; m_blink = 0;
        end else if (m_state == S_RUN || m_state == S_ADJ) begin
            if (m_state == S_ADJ && ((m_ph + 1) % (TICK_DIV / 2)) == 0) m_blink = ~m_blink;
            m_ph = (m_ph + 1) % TICK_DIV;
        end
        m_state = ns;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic pulse_pause();
        pause_p = 1'b1;
        cycle();
        pause_p = 1'b0;
    endtask

    // Set a time through ADJ mode, then return to IDLE
    task automatic load(input int mm, input int ss);
        bit ok_m, ok_s;
        ok_m = 0; ok_s = 0;
        adj = 1'b1; sel = 1'b0; pause_p = 1'b0;
        cycle();
        for (int i = 0; i < 40; i++) begin
            if (int'(minutes) == mm) begin ok_m = 1; break; end
            cycle();
        end
        sel = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (int'(seconds) == ss) begin ok_s = 1; break; end
            cycle();
        end
        adj = 1'b0;
        cycle();
        n_checks++;
        if (!(ok_m && ok_s)) $display("FAIL load_timeout: got %0d:%0d required %0d:%0d", minutes, seconds, mm, ss);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; adj = 0; sel = 0; pause_p = 0; dir = 0;
        model_reset();
        repeat (3) cycle();
        n_checks++;
        if ({minutes, seconds, running, expired, blink} !== 11'd0)
            $display("FAIL reset_state: got %h required %h", {minutes, seconds, running, expired, blink}, 11'd0);
        else n_pass++;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_start();
        dir = 1'b0;
        pulse_pause();
        n_checks++;
        if ({running, seconds} !== {1'b1, 6'd0}) $display("FAIL start_running: got %b/%0d required 1/0", running, seconds);
        else n_pass++;
        repeat (3) cycle();
        n_checks++;
        if (seconds !== 6'd0) $display("FAIL start_3clk: got %0d required 0", seconds);
        else n_pass++;
        cycle();
        n_checks++;
        if ({minutes, seconds} !== {2'd0, 6'd1}) $display("FAIL start_4clk: got %0d:%0d required 0:1", minutes, seconds);
        else n_pass++;
        repeat (4) cycle();
        n_checks++;
        if ({minutes, seconds} !== {2'd0, 6'd2}) $display("FAIL start_8clk: got %0d:%0d required 0:2", minutes, seconds);
        else n_pass++;
        pulse_pause();
        n_checks++;
        if (running !== 1'b0) $display("FAIL start_stop: got %b required 0", running);
        else n_pass++;
    endtask

    task automatic test_up_wrap();
        load(2, 59);
        dir = 1'b0;
        pulse_pause();
        repeat (4) cycle();
        n_checks++;
        if ({minutes, seconds, running} !== {2'd0, 6'd0, 1'b1})
            $display("FAIL up_wrap: got %0d:%0d run=%b required 0:0 run=1", minutes, seconds, running);
        else n_pass++;
        pulse_pause();
    endtask

    task automatic test_countdown();
        load(0, 2);
        dir = 1'b1;
        pulse_pause();
        repeat (4) cycle();
        n_checks++;
        if ({minutes, seconds, running, expired} !== {2'd0, 6'd1, 1'b1, 1'b0})
            $display("FAIL down_0001: got %0d:%0d r=%b e=%b required 0:1 r=1 e=0", minutes, seconds, running, expired);
        else n_pass++;
        repeat (4) cycle();
        n_checks++;
        if ({minutes, seconds, running, expired} !== {2'd0, 6'd0, 1'b0, 1'b1})
            $display("FAIL down_expire: got %0d:%0d r=%b e=%b required 0:0 r=0 e=1", minutes, seconds, running, expired);
        else n_pass++;
        repeat (6) cycle();
        n_checks++;
        if ({minutes, seconds, expired} !== {2'd0, 6'd0, 1'b1})
            $display("FAIL down_hold: got %0d:%0d e=%b required 0:0 e=1", minutes, seconds, expired);
        else n_pass++;
        pulse_pause();
        n_checks++;
        if ({running, expired} !== 2'b00) $display("FAIL down_ack: got r=%b e=%b required 0/0", running, expired);
        else n_pass++;
        // Start at 00:00 counting down: expires on the first tick with no underflow
        pulse_pause();
        repeat (3) cycle();
        n_checks++;
        if ({running, expired} !== 2'b10) $display("FAIL zero_start_run: got r=%b e=%b required 1/0", running, expired);
        else n_pass++;
        cycle();
        n_checks++;
        if ({minutes, seconds, running, expired} !== {2'd0, 6'd0, 1'b0, 1'b1})
            $display("FAIL zero_start_expire: got %0d:%0d r=%b e=%b required 0:0 r=0 e=1", minutes, seconds, running, expired);
        else n_pass++;
        pulse_pause();
        dir = 1'b0;
    endtask

    task automatic test_adjust();
        load(2, 59);
        adj = 1'b1; sel = 1'b0;
        cycle();
        cycle();
        n_checks++;
        if ({minutes, blink} !== {2'd2, 1'b0}) $display("FAIL adj_enter: got %0d blink=%b required 2 blink=0", minutes, blink);
        else n_pass++;
        cycle();
        n_checks++;
        if ({minutes, blink} !== {2'd0, 1'b1}) $display("FAIL adj_min_wrap: got %0d blink=%b required 0 blink=1", minutes, blink);
        else n_pass++;
        cycle();
        n_checks++;
        if ({minutes, blink} !== {2'd0, 1'b1}) $display("FAIL adj_min_hold: got %0d blink=%b required 0 blink=1", minutes, blink);
        else n_pass++;
        cycle();
        n_checks++;
        if ({minutes, blink} !== {2'd1, 1'b0}) $display("FAIL adj_min_step: got %0d blink=%b required 1 blink=0", minutes, blink);
        else n_pass++;
        sel = 1'b1;
        repeat (2) cycle();
        n_checks++;
        if ({minutes, seconds, blink} !== {2'd1, 6'd0, 1'b1})
            $display("FAIL adj_sec_wrap: got %0d:%0d blink=%b required 1:0 blink=1", minutes, seconds, blink);
        else n_pass++;
        adj = 1'b0;
        cycle();
        n_checks++;
        if ({blink, running} !== 2'b00) $display("FAIL adj_exit: got blink=%b r=%b required 0/0", blink, running);
        else n_pass++;
    endtask

    task automatic test_priority();
        adj = 1'b1; pause_p = 1'b1;
        cycle();
        pause_p = 1'b0;
        n_checks++;
        if (running !== 1'b0) $display("FAIL prio_adj_wins: got running=%b required 0", running);
        else n_pass++;
        adj = 1'b0;
        repeat (3) cycle();
        n_checks++;
        if ({running, expired} !== 2'b00) $display("FAIL prio_toggle_lost: got r=%b e=%b required 0/0", running, expired);
        else n_pass++;
    endtask

`ifdef LAP_EN
    task automatic test_lap();
        load(1, 2);
        dir = 1'b0;
        pulse_pause();
        repeat (4) cycle();
        lap_p = 1'b1;
        cycle();
        lap_p = 1'b0;
        n_checks++;
        if ({lap_min, lap_sec, lap_valid} !== {2'd1, 6'd3, 1'b1})
            $display("FAIL lap_capture: got %0d:%0d v=%b required 1:3 v=1", lap_min, lap_sec, lap_valid);
        else n_pass++;
        pulse_pause();
        lap_p = 1'b1;
        cycle();
        lap_p = 1'b0;
        n_checks++;
        if (lap_valid !== 1'b0) $display("FAIL lap_clear: got v=%b required 0", lap_valid);
        else n_pass++;
    endtask
`endif

    task automatic test_async_reset();
        dir = 1'b0;
        pulse_pause();
        repeat (6) cycle();
        n_checks++;
        if ({running, seconds == 6'd0} !== 2'b10) $display("FAIL arst_pre_run: got r=%b s=%0d required r=1 s!=0", running, seconds);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({minutes, seconds, running, expired, blink} !== 11'd0)
            $display("FAIL arst_run: got %h required %h", {minutes, seconds, running, expired, blink}, 11'd0);
        else n_pass++;
        model_reset();
        #2 rst_n = 1'b1;
        adj = 1'b1; sel = 1'b1;
        repeat (3) cycle();
        n_checks++;
        if ({seconds, blink} !== {6'd1, 1'b1}) $display("FAIL arst_pre_adj: got s=%0d blink=%b required 1/1", seconds, blink);
        else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({minutes, seconds, running, expired, blink} !== 11'd0)
            $display("FAIL arst_adj: got %h required %h", {minutes, seconds, running, expired, blink}, 11'd0);
        else n_pass++;
        model_reset();
        adj = 1'b0; sel = 1'b0;
        #2 rst_n = 1'b1;
    endtask

    task automatic test_random();
        logic [10:0] got, want;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 29) == 0) adj = ~adj;
            if ($urandom_range(0, 7) == 0) sel = ~sel;
            if ($urandom_range(0, 39) == 0) dir = ~dir;
            pause_p = ($urandom_range(0, 9) == 0);
`ifdef LAP_EN
            lap_p = ($urandom_range(0, 7) == 0);
`endif
            cycle();
            got  = {minutes, seconds, running, expired, blink};
            want = {2'(m_t / 60), 6'(m_t % 60), m_state == S_RUN, m_state == S_EXP, m_blink};
            n_checks++;
            if (got !== want) $display("FAIL random_outputs cycle %0d: got %h required %h", i, got, want);
            else n_pass++;
`ifdef LAP_EN
            n_checks++;
            if ({lap_min, lap_sec, lap_valid} !== {2'(m_lap_t / 60), 6'(m_lap_t % 60), m_lap_v})
                $display("FAIL random_lap cycle %0d: got %0d:%0d v=%b required %0d:%0d v=%b",
                         i, lap_min, lap_sec, lap_valid, m_lap_t / 60, m_lap_t % 60, m_lap_v);
            else n_pass++;
`endif
        end
        adj = 0; sel = 0; pause_p = 0; dir = 0;
`ifdef LAP_EN
        lap_p = 0;
`endif
    endtask

    initial begin
        test_reset();
        test_start();
        test_up_wrap();
        test_countdown();
        test_adjust();
        test_priority();
`ifdef LAP_EN
        test_lap();
`endif
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/stopwatch_core.md
Name: stopwatch_core

Overview:
- Parametrised timekeeping core for the stopwatch/timer display path.
- Replaces divided-clock counting with clock enables generated inside a single clock domain.
- Adds up/down (countdown) mode, expiry detection, configurable minute range and a blink phase output.
- Consumes already-debounced `sel`/`adj` levels and a pause pulse; drives minute/second values to the seven-segment display block.

Parameters:
- TICK_DIV, 100000000: clk cycles per 1 s tick; must be even and >= 4.
- MAX_MIN, 59: highest minute value; minute width MIN_W = $clog2(MAX_MIN+1), derived as a localparam.
- ADJ_RATE_DIV, 2: adjust steps per second; step period is TICK_DIV/ADJ_RATE_DIV cycles.

Ports:
- clk  in  1  system clock; sole clock of the block.
- rst_n  in  1  asynchronous, active-low reset.
- sel  in  1  debounced level; 0 = adjust minutes, 1 = adjust seconds.
- adj  in  1  debounced level; 1 = adjust mode.
- pause_p  in  1  single-cycle pulse; toggles run/stop and acknowledges expiry.
- dir  in  1  0 = count up, 1 = count down; sampled on every second tick.
- minutes  out  MIN_W  current minutes.
- seconds  out  6  current seconds, 0..59.
- running  out  1  high in RUN.
- expired  out  1  high in EXPIRED.
- blink  out  1  adjust blink phase; toggles every TICK_DIV/2 cycles in ADJ, 0 otherwise.

Behaviour:
- Reset (async assert, sync release): state IDLE; minutes=0, seconds=0; prescaler=0; running=0, expired=0, blink=0.
- Prescaler:
  - Counts 0..TICK_DIV-1 in RUN and ADJ; holds in IDLE and EXPIRED.
  - Cleared on every state change, so the first tick after entering a state comes a full period later.
  - sec_tick fires when prescaler == TICK_DIV-1.
  - adj_step fires when prescaler mod (TICK_DIV/ADJ_RATE_DIV) == last count.
  - blink toggles at prescaler == TICK_DIV/2-1 and at TICK_DIV-1.
- FSM states: IDLE, RUN, ADJ, EXPIRED.
  - adj=1 from any state -> ADJ on the next clk. adj has priority; a pause_p in the same cycle is dropped.
  - ADJ, adj=0 -> IDLE.
  - IDLE, pause_p -> RUN.
  - RUN, pause_p -> IDLE.
  - RUN, countdown reaches 00:00 -> EXPIRED.
  - EXPIRED, pause_p -> IDLE; expired clears.
- Count up (dir=0), on sec_tick:
  - seconds 59 -> 0 with carry; minutes +1.
  - At MAX_MIN:59, wraps to 00:00 and stays in RUN.
- Count down (dir=1), on sec_tick:
  - seconds 0 -> 59 with borrow; minutes -1.
  - Decrement to 00:00 -> EXPIRED the same cycle.
  - RUN entered at 00:00 with dir=1 -> EXPIRED on the first sec_tick; value stays 00:00, no underflow.
- ADJ, on adj_step:
  - sel=0: minutes +1, wrapping MAX_MIN -> 0.
  - sel=1: seconds +1, wrapping 59 -> 0.
  - No carry between fields. sel change takes effect on the next step.
- Outputs are registered; latency from tick to updated value is 1 clk.
- A dir change mid-second applies at the next sec_tick; no prescaler reset.
- rst_n assertion mid-operation clears everything immediately, including in ADJ.

Optional Feature:
- Macro LAP_EN.
- When defined:
  - Adds input lap_p (1) and outputs lap_min (MIN_W), lap_sec (6), lap_valid (1).
  - lap_p in RUN captures minutes/seconds the next clk and sets lap_valid.
  - lap_p in IDLE clears lap_valid.
  - lap_p is ignored in ADJ and EXPIRED.
  - Reset clears all lap outputs.
- When undefined: ports and registers absent; core behaviour identical.

Decomposition:
- Shared package `stopwatch_pkg`:
  - State encoding typedef (IDLE/RUN/ADJ/EXPIRED).
  - SEC_MAX=59 constant.
  - Function for minute width.
- Natural sub-module: `tick_gen`. It holds the prescaler and produces sec_tick, adj_step and blink from clk, rst_n and a clear/enable pair.
- FSM and time registers stay in stopwatch_core.

Test Plan:
- Bench parameters: TICK_DIV=4, MAX_MIN=2.
- Reset and start: rst_n low, then pause_p -> running=1 next clk; seconds reaches 1 after 4 clks, then 2 after 8.
- Up wrap: count up from 02:59 -> next tick gives 00:00; running stays 1.
- Countdown: load 00:02 via ADJ, dir=1, pause_p -> 00:01, then 00:00 with expired=1 and value held. pause_p -> IDLE, expired=0.
- Adjust: adj=1, sel=0 at minutes=2 -> steps every 2 clks go 0 then 1. sel=1 at seconds=59 -> 0 with minutes unchanged. blink toggles every 2 clks.
- Priority and async reset:
  - adj and pause_p in the same cycle -> ADJ entered, run toggle lost.
  - rst_n low mid-RUN -> all outputs 0 without waiting for a clk edge.
- LAP_EN build: lap_p at 01:03 in RUN -> lap_min=1, lap_sec=3, lap_valid=1 next clk. lap_p in IDLE -> lap_valid=0.
